// File: rtl/cam_cfg_pkg.sv
// rtl/cam_cfg_pkg.sv - shared types and constants for the camera config sequencer
// Purpose: state encoding, table tag values and the table entry layout used by
//          cam_config_sequencer.
package cam_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_DELAY,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } cfg_state_t;

  localparam logic [15:0] END_MARKER = 16'hFFFF;
  localparam logic [7:0]  DELAY_TAG  = 8'hFE;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
  } cfg_entry_t;

  // An entry whose address byte is the delay tag carries a millisecond count
  // in its data byte instead of a register value.
  function automatic logic is_delay(input cfg_entry_t e);
    return (e.reg_addr == DELAY_TAG);
  endfunction

endpackage

// File: rtl/ms_delay_timer.sv
// rtl/ms_delay_timer.sv - loadable cycle down-counter with a zero flag
// Purpose: times the power-up wait and the inline table delays.
// Ports:
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   i_load            load i_cycles this cycle
//   i_cycles          number of cycles the consumer should stay in its wait state
//   o_zero            count has expired
module ms_delay_timer #(
  parameter int W = 12
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_cycles,
  output logic         o_zero
);

  logic [W-1:0] count;

  // The load stores N-1 so that a state which loads N on entry and leaves on
  // o_zero occupies exactly N cycles (a load of 0 behaves like a load of 1).
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count <= '0;
    end else if (i_load) begin
      count <= (i_cycles == '0) ? '0 : i_cycles - W'(1);
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign o_zero = (count == '0);

endmodule

// File: rtl/cam_config_sequencer.sv
// rtl/cam_config_sequencer.sv - walks the camera register table and drives the SCCB master
// Purpose: after i_config_start, waits the power-up time, then reads the table one
//          entry at a time, issuing register writes (with NACK retries) and inline
//          millisecond delays until the end marker or the last table entry.
// Ports:
//   i_clk, i_reset_n                    clock, asynchronous active-low reset
//   i_config_start                      level request from the control FSM
//   o_config_done, o_config_error, o_busy  status
//   o_rom_addr, i_rom_data              table ROM (registered, 1-cycle latency)
//   o_sccb_start, o_sccb_reg_addr/data  write launch and its operands
//   i_sccb_ready, i_sccb_done, i_sccb_nack  SCCB master handshake
module cam_config_sequencer
  import cam_cfg_pkg::*;
#(
  parameter  int CLK_FREQ_HZ    = 25_000_000,
  parameter  int ROM_DEPTH      = 64,
  parameter  int PWRUP_DELAY_MS = 3,
  parameter  int MAX_RETRY      = 3,
  localparam int ROM_AW         = $clog2(ROM_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_config_start,
  output logic              o_config_done,
  output logic              o_config_error,
  output logic              o_busy,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_sccb_start,
  output logic [7:0]        o_sccb_reg_addr,
  output logic [7:0]        o_sccb_reg_data,
  input  logic              i_sccb_ready,
  input  logic              i_sccb_done,
  input  logic              i_sccb_nack
);

  localparam int MS_CYC     = CLK_FREQ_HZ / 1000;
  localparam int DLY_MS_MAX = (PWRUP_DELAY_MS > 255) ? PWRUP_DELAY_MS : 255;
  localparam int DLY_W      = $clog2(DLY_MS_MAX * MS_CYC + 1);
  localparam int RETRY_W    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [DLY_W-1:0]   PWRUP_CYC   = DLY_W'(PWRUP_DELAY_MS * MS_CYC);
  localparam logic [DLY_W-1:0]   MS_CYC_W    = DLY_W'(MS_CYC);
  localparam logic [ROM_AW-1:0]  LAST_ADDR   = ROM_AW'(ROM_DEPTH - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  cfg_state_t         state, state_n;
  logic [ROM_AW-1:0]  rom_addr_n;
  logic [7:0]         reg_addr_n, reg_data_n;
  logic [RETRY_W-1:0] retry, retry_n;
  logic               tmr_load;
  logic [DLY_W-1:0]   tmr_cycles;
  logic               tmr_zero;
  cfg_entry_t         entry;

  assign entry = cfg_entry_t'(i_rom_data);

  ms_delay_timer #(.W(DLY_W)) u_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_load    (tmr_load),
    .i_cycles  (tmr_cycles),
    .o_zero    (tmr_zero)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state           <= ST_IDLE;
      o_rom_addr      <= '0;
      o_sccb_reg_addr <= '0;
      o_sccb_reg_data <= '0;
      retry           <= '0;
    end else begin
      state           <= state_n;
      o_rom_addr      <= rom_addr_n;
      o_sccb_reg_addr <= reg_addr_n;
      o_sccb_reg_data <= reg_data_n;
      retry           <= retry_n;
    end
  end

  always_comb begin
    state_n      = state;
    rom_addr_n   = o_rom_addr;
    reg_addr_n   = o_sccb_reg_addr;
    reg_data_n   = o_sccb_reg_data;
    retry_n      = retry;
    tmr_load     = 1'b0;
    tmr_cycles   = '0;
    o_sccb_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_config_start) begin
          state_n    = ST_PWRUP;
          tmr_load   = 1'b1;
          tmr_cycles = PWRUP_CYC;
          rom_addr_n = '0;
        end
      end
      ST_PWRUP: begin
        if (tmr_zero) state_n = ST_FETCH;
      end
      // o_rom_addr is already driven; this cycle lets the registered ROM respond.
      ST_FETCH: state_n = ST_DECODE;
      ST_DECODE: begin
        if (i_rom_data == END_MARKER) begin
          state_n = ST_DONE;
        end else if (is_delay(entry)) begin
          tmr_load   = 1'b1;
          tmr_cycles = DLY_W'(entry.reg_data) * MS_CYC_W;
          state_n    = ST_DELAY;
        end else begin
          reg_addr_n = entry.reg_addr;
          reg_data_n = entry.reg_data;
          retry_n    = '0;
          state_n    = ST_ISSUE;
        end
      end
      // Start is combinational on ready so the write launches in the same cycle.
      ST_ISSUE: begin
        if (i_sccb_ready) begin
          o_sccb_start = 1'b1;
          state_n      = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_sccb_done) begin
          if (!i_sccb_nack) begin
            state_n = ST_NEXT;
          end else if (retry < RETRY_LIMIT) begin
            retry_n = retry + RETRY_W'(1);
            state_n = ST_ISSUE;
          end else begin
            state_n = ST_ERROR;
          end
        end
      end
      ST_DELAY: begin
        if (tmr_zero) state_n = ST_NEXT;
      end
      // A table without an end marker finishes on its last entry; no wrap.
      ST_NEXT: begin
        if (o_rom_addr == LAST_ADDR) begin
          state_n = ST_DONE;
        end else begin
          rom_addr_n = o_rom_addr + ROM_AW'(1);
          state_n    = ST_FETCH;
        end
      end
      ST_DONE: begin
        if (!i_config_start) state_n = ST_IDLE;
      end
      ST_ERROR: state_n = ST_ERROR;
      default:  state_n = ST_IDLE;
    endcase
  end

  assign o_config_done  = (state == ST_DONE) || (state == ST_ERROR);
  assign o_config_error = (state == ST_ERROR);
  assign o_busy         = !((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));

endmodule

// File: tb/tb_cam_config_sequencer.sv
// tb/tb_cam_config_sequencer.sv - randomized self-checking bench for cam_config_sequencer
module tb_cam_config_sequencer;

  localparam int DEPTH    = 4;
  localparam int MS       = 10;
  localparam int PWRUP    = 10;
  localparam int NRETRY   = 3;
  localparam int SCCB_LAT = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        config_start = 1'b0;
  logic        config_done, config_error, busy;
  logic [1:0]  rom_addr;
  logic [15:0] rom_data = '0;
  logic        sccb_start;
  logic [7:0]  sccb_reg_addr, sccb_reg_data;
  logic        sccb_ready = 1'b0;
  logic        sccb_done = 1'b0;
  logic        sccb_nack = 1'b0;
  logic [15:0] rom_tbl [DEPTH];

  cam_config_sequencer #(
    .CLK_FREQ_HZ(10_000), .ROM_DEPTH(DEPTH), .PWRUP_DELAY_MS(1), .MAX_RETRY(NRETRY)
  ) dut (
    .i_clk           (clk),
    .i_reset_n       (reset_n),
    .i_config_start  (config_start),
    .o_config_done   (config_done),
    .o_config_error  (config_error),
    .o_busy          (busy),
    .o_rom_addr      (rom_addr),
    .i_rom_data      (rom_data),
    .o_sccb_start    (sccb_start),
    .o_sccb_reg_addr (sccb_reg_addr),
    .o_sccb_reg_data (sccb_reg_data),
    .i_sccb_ready    (sccb_ready),
    .i_sccb_done     (sccb_done),
    .i_sccb_nack     (sccb_nack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_tbl[rom_addr];

  int n_total = 0;
  int n_bad   = 0;
  int ncyc    = 0;

  bit pend = 0;
  int done_at = 0;
  bit hold_ready = 0;
  bit spurious = 0;
  bit nack_q[$];
  bit plan_q[$];

  int         st_cyc[$];
  logic [7:0] st_addr[$];
  logic [7:0] st_data[$];
  int         dn_cyc[$];
  int         done_rise = -1;

  logic [7:0] ex_addr[$];
  logic [7:0] ex_data[$];
  int         ex_min[$];
  bit         ex_exact[$];
  bit         exp_err;
  int         exp_fin_idx;
  int         exp_fin_min;
  bit         exp_fin_exact;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  // One clock: drive the SCCB-master side at the falling edge, then log outputs.
  task automatic tick();
    @(negedge clk);
    ncyc++;
    sccb_done = 1'b0;
    sccb_nack = 1'b0;
    if (pend && ncyc == done_at) begin
      check_eq("regs_held_until_done", 32'({sccb_reg_addr, sccb_reg_data}),
               32'({st_addr[$], st_data[$]}));
      sccb_done = 1'b1;
      sccb_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
      pend = 1'b0;
      dn_cyc.push_back(ncyc);
    end else if (spurious && !pend && $urandom_range(0, 9) == 0) begin
      sccb_done = 1'b1;
      sccb_nack = 1'($urandom_range(0, 1));
    end
    sccb_ready = !pend && !hold_ready;
    #1;
    if (sccb_start) begin
      check_eq("start_only_when_ready", 32'(sccb_ready), 32'd1);
      st_cyc.push_back(ncyc);
      st_addr.push_back(sccb_reg_addr);
      st_data.push_back(sccb_reg_data);
      pend = 1'b1;
      done_at = ncyc + SCCB_LAT;
    end
    if (config_done && done_rise < 0) done_rise = ncyc;
  endtask

  task automatic clear_logs();
    st_cyc.delete(); st_addr.delete(); st_data.delete(); dn_cyc.delete();
    done_rise = -1;
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("reset_outputs_zero",
             32'({config_done, config_error, busy, sccb_start, rom_addr, sccb_reg_addr, sccb_reg_data}),
             32'd0);
    pend = 1'b0;
    nack_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic set_tbl(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
    rom_tbl[0] = a; rom_tbl[1] = b; rom_tbl[2] = c; rom_tbl[3] = d;
  endtask

  // Reference: walk the table by its rules, producing the writes expected on the bus
  // and the minimum (or exact) distance of each from its reference event.
  task automatic build_expect(input int first_min);
    int k;
    int rmin;
    bit exact;
    bit nk;
    logic [15:0] e;
    k = 0; rmin = first_min; exact = 1'b1;
    ex_addr.delete(); ex_data.delete(); ex_min.delete(); ex_exact.delete();
    exp_err = 1'b0; exp_fin_idx = DEPTH - 1; exp_fin_min = 1; exp_fin_exact = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      e = rom_tbl[i];
      if (e == 16'hFFFF) begin
        exp_fin_idx = i; exp_fin_min = rmin; exp_fin_exact = exact;
        return;
      end
      if (e[15:8] == 8'hFE) begin
        rmin += int'(e[7:0]) * MS;
        exact = 1'b0;
        continue;
      end
      for (int a = 0; a <= NRETRY; a++) begin
        nk = (k < plan_q.size()) ? plan_q[k] : 1'b0;
        k++;
        ex_addr.push_back(e[15:8]); ex_data.push_back(e[7:0]);
        ex_min.push_back(rmin); ex_exact.push_back(exact);
        if (!nk) break;
        rmin = 1; exact = 1'b0;
        if (a == NRETRY) begin
          exp_err = 1'b1; exp_fin_idx = i; exp_fin_min = 1; exp_fin_exact = 1'b0;
          return;
        end
      end
      rmin = 4; exact = 1'b1;
    end
  endtask

  task automatic run_seq(input int hold, input bit drop_mid, input bit spur);
    int t0;
    int budget;
    int ref_c;
    int gap;
    int n_before;
    clear_logs();
    nack_q = plan_q;
    spurious = spur;
    build_expect((hold > PWRUP + 3) ? hold : PWRUP + 3);
    config_start = 1'b1;
    t0 = ncyc;
    budget = 0;
    while (done_rise < 0 && budget < 4000) begin
      hold_ready = (ncyc + 1 - t0) < hold;
      tick();
      budget++;
      if (drop_mid && st_cyc.size() > 0) config_start = 1'b0;
    end
    hold_ready = 1'b0;
    spurious = 1'b0;
    check_eq("done_reached", 32'(config_done), 32'd1);
    check_eq("write_count", 32'(st_cyc.size()), 32'(ex_addr.size()));
    for (int j = 0; j < st_cyc.size() && j < ex_addr.size(); j++) begin
      ref_c = (j > 0 && j - 1 < dn_cyc.size()) ? dn_cyc[j-1] : t0;
      gap = st_cyc[j] - ref_c;
      check_eq($sformatf("wr%0d_addr", j), 32'(st_addr[j]), 32'(ex_addr[j]));
      check_eq($sformatf("wr%0d_data", j), 32'(st_data[j]), 32'(ex_data[j]));
      if (ex_exact[j]) check_eq($sformatf("wr%0d_latency", j), 32'(gap), 32'(ex_min[j]));
      else check_eq($sformatf("wr%0d_latency_ge_%0d", j, ex_min[j]), 32'(gap >= ex_min[j]), 32'd1);
    end
    ref_c = (dn_cyc.size() > 0) ? dn_cyc[dn_cyc.size()-1] : t0;
    if (exp_fin_exact) check_eq("done_latency", 32'(done_rise - ref_c), 32'(exp_fin_min));
    else check_eq("done_latency_min", 32'(done_rise - ref_c >= exp_fin_min), 32'd1);
    check_eq("error_flag", 32'(config_error), 32'(exp_err));
    check_eq("busy_at_done", 32'(busy), 32'd0);
    check_eq("final_rom_addr", 32'(rom_addr), 32'(exp_fin_idx));
    if (!exp_err) begin
      config_start = 1'b0;
      tick();
      check_eq("done_drops", 32'(config_done), 32'd0);
    end else begin
      config_start = 1'b0;
      repeat (3) tick();
      config_start = 1'b1;
      n_before = st_cyc.size();
      repeat (40) tick();
      check_eq("error_no_more_starts", 32'(st_cyc.size()), 32'(n_before));
      check_eq("error_done_held", 32'(config_done), 32'd1);
      check_eq("error_sticky", 32'(config_error), 32'd1);
      config_start = 1'b0;
      do_reset();
    end
  endtask

  initial begin
    int r;
    set_tbl(16'h0, 16'h0, 16'h0, 16'h0);
    do_reset();
    check_eq("idle_not_busy", 32'(busy), 32'd0);

    // Two plain writes then the end marker.
    set_tbl(16'h1280, 16'h1204, 16'hFFFF, 16'h0000);
    plan_q.delete();
    run_seq(0, 1'b0, 1'b0);

    // Inline 5 ms delay, then a zero-length delay.
    set_tbl(16'h1280, 16'hFE05, 16'h1204, 16'hFFFF);
    run_seq(0, 1'b0, 1'b0);
    set_tbl(16'h1280, 16'hFE00, 16'h1204, 16'hFFFF);
    run_seq(0, 1'b0, 1'b0);

    // Two NACKs on entry 0, third attempt succeeds.
    set_tbl(16'h1280, 16'h1204, 16'hFFFF, 16'h0000);
    plan_q = {1'b1, 1'b1};
    run_seq(0, 1'b0, 1'b0);

    // Persistent NACK exhausts the retries.
    plan_q = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    run_seq(0, 1'b0, 1'b0);

    // SCCB master not ready for 100 cycles after the sequencer reaches ISSUE.
    set_tbl(16'h1280, 16'hFFFF, 16'h0000, 16'h0000);
    plan_q.delete();
    run_seq(PWRUP + 3 + 100, 1'b0, 1'b0);

    // Reset while entry 1 is being written, then replay from entry 0.
    set_tbl(16'h1280, 16'h1204, 16'hFFFF, 16'h0000);
    clear_logs();
    nack_q.delete();
    config_start = 1'b1;
    for (int i = 0; i < 400 && st_cyc.size() < 2; i++) tick();
    check_eq("mid_reset_reached_entry1", 32'(st_cyc.size()), 32'd2);
    repeat (5) tick();
    check_eq("mid_reset_busy", 32'(busy), 32'd1);
    config_start = 1'b0;
    do_reset();
    run_seq(0, 1'b0, 1'b0);

    // Table filling the ROM with no end marker.
    set_tbl(16'h1280, 16'h1204, 16'h1308, 16'h1410);
    run_seq(0, 1'b0, 1'b0);

    // Random tables, NACK patterns, mid-run start drops and stray done pulses.
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < DEPTH; i++) begin
        r = $urandom_range(0, 9);
        if (r < 6) rom_tbl[i] = {8'($urandom_range(0, 253)), 8'($urandom)};
        else if (r < 8) rom_tbl[i] = {8'hFE, 8'($urandom_range(0, 3))};
        else rom_tbl[i] = 16'hFFFF;
      end
      plan_q.delete();
      r = $urandom_range(0, 4);
      for (int k = 0; k < 16; k++) plan_q.push_back((r == 0 && k < 8) ? 1'b1 : ($urandom_range(0, 3) == 0));
      run_seq(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
